// File: rtl/fp_pkg.sv
// Shared types and constants for the fp_add_sub floating-point adder/subtractor.
// Holds the FSM state encoding, status bit positions and default field widths.
package fp_pkg;

    localparam int DEF_EXP_W = 6;
    localparam int DEF_MAN_W = 25;

    localparam int ST_EXACT     = 0;
    localparam int ST_OVERFLOW  = 1;
    localparam int ST_UNDERFLOW = 2;
    localparam int ST_INEXACT   = 3;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ALIGN = 3'd1,
        S_ADD   = 3'd2,
        S_NORM  = 3'd3,
        S_ROUND = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    function automatic logic [3:0] status_onehot(input int idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/fp_add_sub_if.sv
// Operand/result bus of fp_add_sub: one request channel and one response channel.
// Both channels use valid/ready: a transfer happens on a rising edge where valid && ready;
// the sender keeps valid and its payload stable until that edge.
interface fp_add_sub_if #(parameter int W = 32);

    logic         in_valid;
    logic         in_ready;
    logic         op_sub;
    logic [W-1:0] op_A_in;
    logic [W-1:0] op_B_in;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] data_out;
    logic [3:0]   status_out;

    modport master (
        output in_valid, op_sub, op_A_in, op_B_in, out_ready,
        input  in_ready, out_valid, data_out, status_out
    );

    modport slave (
        input  in_valid, op_sub, op_A_in, op_B_in, out_ready,
        output in_ready, out_valid, data_out, status_out
    );

endinterface

// File: rtl/fp_align_shifter.sv
// Right shifter for the smaller mantissa; bits shifted out are OR-ed into the sticky bit (bit 0).
module fp_align_shifter #(
    parameter int MAN_W = 25,
    parameter int EXP_W = 6
) (
    input  logic [MAN_W+3:0] i_man,
    input  logic [EXP_W-1:0] i_shamt,
    output logic [MAN_W+3:0] o_man
);

    localparam int DW = MAN_W + 4;
    localparam logic [EXP_W-1:0] MAX_SH = EXP_W'(MAN_W + 2);

    logic [DW-1:0] w_mask;
    logic          w_sticky;

    always_comb begin
        w_mask   = ~({DW{1'b1}} << i_shamt);
        w_sticky = |(i_man & w_mask);
        if (i_shamt > MAX_SH) begin
            o_man = {{(DW-1){1'b0}}, |i_man};
        end else begin
            o_man = (i_man >> i_shamt) | {{(DW-1){1'b0}}, w_sticky};
        end
    end

endmodule

// File: rtl/fp_add_sub.sv
// Multi-cycle floating-point add/subtract: IDLE->ALIGN->ADD->NORM->ROUND->DONE.
// Define FP_ROUND_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_add_sub
    import fp_pkg::*;
#(
    parameter int EXP_W = DEF_EXP_W,
    parameter int MAN_W = DEF_MAN_W
) (
    input  logic         clock_100kHz,
    input  logic         reset,
    fp_add_sub_if.slave  bus,
    output state_t       o_dbg_state
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int DW = MAN_W + 4;
    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    state_t         r_state, w_next;
    logic [W-1:0]   r_a, r_b;
    logic           r_sign, r_eff_sub, r_unf, r_zero;
    logic [EXP_W:0] r_exp;
    logic [DW-1:0]  r_man_a, r_man_b;
    logic [DW:0]    r_man;
    logic [W-1:0]   r_data;
    logic [3:0]     r_status;

    logic           w_swap;
    logic [W-1:0]   w_big, w_small;
    logic [EXP_W-1:0] w_big_exp, w_small_exp, w_shamt;
    logic [DW-1:0]  w_big_man, w_small_man, w_small_sh;
    logic           w_carry, w_is_zero, w_hidden, w_exp_floor, w_norm_done;
    logic [EXP_W:0] w_fin_exp;
    logic [MAN_W-1:0] w_fin_frac;
    logic           w_inexact;
    logic [W-1:0]   w_res;
    logic [3:0]     w_res_st;

    // Raw {exp, frac} compare orders magnitudes since the exponent sits above the fraction.
    always_comb begin
        w_swap      = r_b[W-2:0] > r_a[W-2:0];
        w_big       = w_swap ? r_b : r_a;
        w_small     = w_swap ? r_a : r_b;
        w_big_exp   = w_big[W-2:MAN_W];
        w_small_exp = w_small[W-2:MAN_W];
        w_big_man   = (w_big_exp == '0) ? '0 : {1'b1, w_big[MAN_W-1:0], 3'b000};
        w_small_man = (w_small_exp == '0) ? '0 : {1'b1, w_small[MAN_W-1:0], 3'b000};
        w_shamt     = w_big_exp - w_small_exp;
    end

    fp_align_shifter #(.MAN_W(MAN_W), .EXP_W(EXP_W)) u_shift (
        .i_man   (w_small_man),
        .i_shamt (w_shamt),
        .o_man   (w_small_sh)
    );

    always_comb begin
        w_carry     = r_man[DW];
        w_is_zero   = (r_man == '0);
        w_hidden    = r_man[DW-1];
        w_exp_floor = (r_exp == {{EXP_W{1'b0}}, 1'b1});
        w_norm_done = w_carry | w_is_zero | w_hidden | w_exp_floor;
    end

`ifdef FP_ROUND_EN
    logic [MAN_W+1:0] w_rsum;
    logic             w_round_up;
    always_comb begin
        w_round_up = r_man[2] & (r_man[1] | r_man[0] | r_man[3]);
        w_rsum     = {1'b0, r_man[DW-1:3]} + {{(MAN_W+1){1'b0}}, w_round_up};
        if (w_rsum[MAN_W+1]) begin
            w_fin_exp  = r_exp + 1'b1;
            w_fin_frac = w_rsum[MAN_W:1];
        end else begin
            w_fin_exp  = r_exp;
            w_fin_frac = w_rsum[MAN_W-1:0];
        end
    end
`else
    always_comb begin
        w_fin_exp  = r_exp;
        w_fin_frac = r_man[DW-2:3];
    end
`endif

    always_comb begin
        w_inexact = |r_man[2:0];
        if (r_zero) begin
            w_res    = '0;
            w_res_st = status_onehot(ST_EXACT);
        end else if (r_unf) begin
            w_res    = {r_sign, {(W-1){1'b0}}};
            w_res_st = status_onehot(ST_UNDERFLOW);
        end else if (w_fin_exp >= EXP_MAX) begin
            w_res    = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            w_res_st = status_onehot(ST_OVERFLOW);
        end else begin
            w_res    = {r_sign, w_fin_exp[EXP_W-1:0], w_fin_frac};
            w_res_st = status_onehot(w_inexact ? ST_INEXACT : ST_EXACT);
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.in_valid) w_next = S_ALIGN;
            S_ALIGN: w_next = S_ADD;
            S_ADD:   w_next = S_NORM;
            S_NORM:  if (w_norm_done) w_next = S_ROUND;
            S_ROUND: w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clock_100kHz or negedge reset) begin
        if (!reset) begin
            r_a <= '0; r_b <= '0; r_sign <= 1'b0; r_eff_sub <= 1'b0;
            r_unf <= 1'b0; r_zero <= 1'b0; r_exp <= '0;
            r_man_a <= '0; r_man_b <= '0; r_man <= '0;
            r_data <= '0; r_status <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.in_valid) begin
                    r_a    <= bus.op_A_in;
                    r_b    <= {bus.op_B_in[W-1] ^ bus.op_sub, bus.op_B_in[W-2:0]};
                    r_zero <= 1'b0;
                    r_unf  <= 1'b0;
                end
                S_ALIGN: begin
                    r_man_a   <= w_big_man;
                    r_man_b   <= w_small_sh;
                    r_exp     <= {1'b0, w_big_exp};
                    r_sign    <= w_big[W-1];
                    r_eff_sub <= w_big[W-1] ^ w_small[W-1];
                end
                S_ADD: r_man <= r_eff_sub ? ({1'b0, r_man_a} - {1'b0, r_man_b})
                                          : ({1'b0, r_man_a} + {1'b0, r_man_b});
                S_NORM: begin
                    if (w_carry) begin
                        r_man <= {1'b0, r_man[DW:2], r_man[1] | r_man[0]};
                        r_exp <= r_exp + 1'b1;
                    end else if (w_is_zero) begin
                        r_zero <= 1'b1;
                    end else if (!w_hidden) begin
                        r_man <= r_man << 1;
                        r_exp <= r_exp - 1'b1;
                        if (w_exp_floor) r_unf <= 1'b1;
                    end
                end
                S_ROUND: begin
                    r_data   <= w_res;
                    r_status <= w_res_st;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.out_valid  = (r_state == S_DONE);
    assign bus.data_out   = r_data;
    assign bus.status_out = r_status;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_fp_add_sub.sv
// Directed-vector bench for fp_add_sub: driver pushes expected results, a monitor pops and compares.
`timescale 1ns/1ps
module tb_fp_add_sub;
    import fp_pkg::*;

    localparam int W = 32;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    state_t dbg_state;
    int     checks = 0;
    int     errors = 0;
    int     cyc = 0;
    logic   prev_v = 1'b0;

    logic [W-1:0] exp_q[$];
    logic [3:0]   st_q[$];
    int           rise_q[$];

    fp_add_sub_if #(.W(W)) bus();

    fp_add_sub #(.EXP_W(6), .MAN_W(25)) dut (
        .clock_100kHz (clk),
        .reset        (rst_n),
        .bus          (bus.slave),
        .o_dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Monitor: latency on the rising edge of out_valid, payload at the accepting handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && !prev_v) begin
                if (rise_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got out_valid=1 with data %0h, expected no result", bus.data_out);
                end else if (rise_q[0] >= 0) begin
                    check("latency_cycle", cyc, rise_q[0]);
                end
            end
            if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
                check("data_out", bus.data_out, exp_q.pop_front());
                check("status_out", bus.status_out, st_q.pop_front());
                void'(rise_q.pop_front());
            end
        end
        prev_v = bus.out_valid;
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W-1:0] ed, input logic [3:0] es, input int lat, input bit push);
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: got in_ready=0, expected 1 within 300 cycles");
            return;
        end
        bus.op_A_in  = a;
        bus.op_B_in  = b;
        bus.op_sub   = sub;
        bus.in_valid = 1'b1;
        if (push) begin
            exp_q.push_back(ed);
            st_q.push_back(es);
            rise_q.push_back(lat < 0 ? -1 : cyc + 1 + lat);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got %0d pending results, expected 0", exp_q.size());
            exp_q.delete();
            st_q.delete();
            rise_q.delete();
        end
    endtask

    task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                       input logic [W-1:0] ed, input logic [3:0] es, input int lat);
        issue(a, b, sub, ed, es, lat, 1'b1);
        wait_idle();
    endtask

    initial begin
        int n;
        bus.in_valid  = 1'b0;
        bus.op_sub    = 1'b0;
        bus.op_A_in   = '0;
        bus.op_B_in   = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_data_out", bus.data_out, 0);
        check("rst_status", bus.status_out, 0);
        check("rst_state", dbg_state, S_IDLE);
        rst_n = 1'b1;

        run(32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'b0001, 4);
        run(32'h3E000000, 32'h3E000000, 1'b1, 32'h00000000, 4'b0001, 4);
        run(32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, 32'h7E000000, 4'b0010, 4);
        run(32'h03000000, 32'h02000000, 1'b1, 32'h00000000, 4'b0100, -1);
        run(32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'b1000, 4);
        run(32'h3E000000, 32'h3C000000, 1'b1, 32'h3C000000, 4'b0001, 5);
        run(32'h3F000000, 32'h3E000000, 1'b0, 32'h40800000, 4'b0001, 4);
        run(32'hBE000000, 32'hBE000000, 1'b0, 32'hC0000000, 4'b0001, 4);
        run(32'h3E000000, 32'hC0000000, 1'b0, 32'hBE000000, 4'b0001, 5);
        run(32'h00000000, 32'h3E000000, 1'b0, 32'h3E000000, 4'b0001, 4);
        run(32'h3E000000, 32'h06000000, 1'b0, 32'h3E000000, 4'b1000, 4);
        run(32'h7C000000, 32'h3E000000, 1'b0, 32'h7C000000, 4'b1000, 4);
        run(32'h3E000001, 32'h3E000000, 1'b1, 32'h0C000000, 4'b0001, 29);
`ifdef FP_ROUND_EN
        run(32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000002, 4'b1000, 4);
`else
        run(32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000001, 4'b1000, 4);
`endif

        // Backpressure: result must hold while out_ready is low.
        bus.out_ready = 1'b0;
        issue(32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'b0001, 4, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        repeat (10) begin
            @(negedge clk);
            check("bp_out_valid", bus.out_valid, 1);
            check("bp_data_out", bus.data_out, 32'h40000000);
            check("bp_status", bus.status_out, 4'b0001);
            check("bp_in_ready", bus.in_ready, 0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        wait_idle();

        // Reset during NORM aborts the long-cancellation operation.
        issue(32'h3E000001, 32'h3E000000, 1'b1, '0, 4'b0000, -1, 1'b0);
        n = 0;
        while (dbg_state != S_NORM && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reached_norm", dbg_state, S_NORM);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("abort_out_valid", bus.out_valid, 0);
        check("abort_data_out", bus.data_out, 0);
        check("abort_status", bus.status_out, 0);
        check("abort_in_ready", bus.in_ready, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("post_abort_in_ready", bus.in_ready, 1);
        check("post_abort_out_valid", bus.out_valid, 0);

        run(32'h3F000000, 32'h3E000000, 1'b0, 32'h40800000, 4'b0001, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_add_sub.md
FP_ADD_SUB -- requirements
Module: fp_add_sub

Interface
REQ-001 SHALL have parameter EXP_W, default 6, exponent field width; exponent bias is 2^(EXP_W-1)-1.
REQ-002 SHALL have parameter MAN_W, default 25, stored-fraction width; word width W = 1+EXP_W+MAN_W (default 32).
REQ-003 clock_100kHz  input  1  the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  operands and op_sub are valid.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 op_sub  input  1  0 = A+B, 1 = A-B; B's sign is inverted before processing.
REQ-008 op_A_in, op_B_in  input  W  operands; bit W-1 = sign, next EXP_W bits = exponent, low MAN_W bits = fraction; hidden 1 is implicit.
REQ-009 out_valid  output  1  data_out and status_out are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 data_out  output  W  result in the same format.
REQ-012 status_out  output  4  one-hot: [0] exact, [1] overflow, [2] underflow, [3] inexact.

Function
REQ-013 SHALL run FSM IDLE -> ALIGN -> ADD -> NORM -> ROUND -> DONE -> IDLE.
REQ-014 in_ready SHALL be 1 only in IDLE; capture SHALL occur on an edge with in_valid && in_ready.
REQ-015 ALIGN SHALL swap so that A holds the larger magnitude (exponent, then fraction) and SHALL right-shift B by the exponent difference, keeping guard, round and sticky bits; a difference > MAN_W+2 SHALL leave only sticky.
REQ-016 ADD SHALL add the magnitudes on equal effective signs and subtract otherwise, in a MAN_W+4-bit datapath; the result sign SHALL be the sign of the larger operand.
REQ-017 NORM SHALL handle a carry-out with one right shift and exponent+1 in its first cycle; otherwise it SHALL shift left by one bit per cycle, decrementing the exponent, until the hidden bit is 1.
REQ-018 out_valid SHALL rise on the (4+k)th edge after capture, where k = number of left shifts (0 <= k <= MAN_W+2).
REQ-019 An operand with exponent field 0 SHALL be treated as zero; an exact zero result SHALL produce data_out = 0 (positive sign) and status exact, with k = 0.
REQ-020 A biased exponent reaching all-ones SHALL give data_out = sign, all-ones exponent, zero fraction, and status overflow.
REQ-021 An exponent reaching 0 during NORM SHALL stop normalisation and give a signed zero with status underflow.
REQ-022 If no flag applies, status SHALL be inexact when any of guard/round/sticky was nonzero before ROUND, and exact otherwise; exactly one bit SHALL be set.
REQ-023 In DONE, out_valid, data_out and status_out SHALL hold stable until out_ready; the FSM SHALL then go to IDLE on that edge, and out_valid SHALL fall.

Reset
REQ-024 Reset SHALL force IDLE, in_ready=1, out_valid=0, data_out=0, status_out=0 and clear all internal registers.
REQ-025 A reset mid-operation SHALL abort it with no result emitted.

Configuration
REQ-026 With FP_ROUND_EN defined, ROUND SHALL round to nearest-even from guard/round/sticky; a rounding carry SHALL renormalise (exponent+1) in the same cycle, and the overflow check SHALL be repeated.
REQ-027 Without FP_ROUND_EN, ROUND SHALL truncate; it SHALL still take one cycle and still report inexact.

Structure
REQ-028 Package fp_pkg SHALL hold the state enum, the status bit-index constants and the default EXP_W/MAN_W.
REQ-029 Sub-module fp_align_shifter SHALL implement the variable right shift with sticky collection.

Verification (defaults, hex)
REQ-030 Test 1: A=3E000000, B=3E000000, op_sub=0 -> data_out=40000000, status=0001, out_valid 4 edges after capture.
REQ-031 Test 2: A=3E000000, B=3E000000, op_sub=1 -> data_out=00000000, status=0001.
REQ-032 Test 3: A=B=7DFFFFFF, add -> data_out=7E000000, status=0010.
REQ-033 Test 4: A=03000000, B=02000000, sub -> data_out=00000000, status=0100.
REQ-034 Test 5: A=3E000000, B=0A000000, add -> data_out=3E000000, status=1000, both with and without FP_ROUND_EN.
REQ-035 Test 6 (backpressure/reset): out_ready low 10 cycles -> outputs stable and in_ready=0; reset asserted in NORM -> all outputs 0 and in_ready=1 next cycle.
